// File: rtl/pipe_mem_pkg.sv
// ---------------------------------------------------------------------------
// pipe_mem_pkg
//   Shared types and helpers for the pipeline memory arbiter slice.
//
//   Contents:
//     ST_*         raw state encodings (kept for legacy waveform/decoder tools)
//     state_t      arbiter FSM states: IDLE, DM_XFER, IF_XFER
//     grant_t      identity of the last requester granted: GRANT_IF, GRANT_DM
//     BLOCK_IDX_W  word-index width for the default 4-word refill block
//     idx_width()  word-index width for an arbitrary block size
// ---------------------------------------------------------------------------
package pipe_mem_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_DM_XFER = 2'd1;
   localparam logic [1:0] ST_IF_XFER = 2'd2;

   typedef enum logic [1:0] {
      IDLE    = ST_IDLE,
      DM_XFER = ST_DM_XFER,
      IF_XFER = ST_IF_XFER
   } state_t;

   typedef enum logic {
      GRANT_IF = 1'b0,
      GRANT_DM = 1'b1
   } grant_t;

   localparam int unsigned BLOCK_WORDS_DEF = 4;
   localparam int unsigned BLOCK_IDX_W     = $clog2(BLOCK_WORDS_DEF);

   // Width of a word index within a refill block; never narrower than 1 bit.
   function automatic int unsigned idx_width(input int unsigned words);
      return (words < 2) ? 1 : $clog2(words);
   endfunction

endpackage

// File: rtl/pipe_mem_arbiter_refill_counter.sv
// ---------------------------------------------------------------------------
// refill_counter
//   Word counter for the icache refill burst plus the burst address adder.
//
//   Ports:
//     clk        system clock, rising edge
//     rst_n      synchronous active-low reset (cnt -> 0)
//     clr        force cnt to 0 on the next edge
//     inc        advance cnt on the next edge (wraps after the last word)
//     base       block-aligned burst base address
//     cnt        current word index
//     last       cnt addresses the final word of the block
//     next_addr  base + (value cnt takes on the next edge), modulo 2^ADDR_W
// ---------------------------------------------------------------------------
module refill_counter
   import pipe_mem_pkg::*;
#(
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned BLOCK_WORDS = 4
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              clr,
   input  logic                              inc,
   input  logic [ADDR_W-1:0]                 base,
   output logic [idx_width(BLOCK_WORDS)-1:0] cnt,
   output logic                              last,
   output logic [ADDR_W-1:0]                 next_addr
);

   localparam int unsigned      IDX_W    = idx_width(BLOCK_WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

   logic [IDX_W-1:0] cnt_next;

   always_comb begin
      cnt_next = cnt;
      if (clr) begin
         cnt_next = '0;
      end else if (inc) begin
         cnt_next = cnt + IDX_W'(1);
      end
   end

   // Address of the word that will be on the bus after this edge, so the
   // arbiter can register mem_addr without waiting a cycle for cnt.
   assign next_addr = base + ADDR_W'(cnt_next);
   assign last      = (cnt == LAST_IDX);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_next;
      end
   end

endmodule

// File: rtl/pipe_mem_arbiter.sv
// ---------------------------------------------------------------------------
// pipe_mem_arbiter
//   Shares the single backing-memory port between the icache refill engine
//   (BLOCK_WORDS-word burst) and the MEM-stage data access (one word), and
//   produces the global pipeline stall.
//
//   Ports:
//     clk, rst_n      clock (rising edge), synchronous active-low reset
//     if_req          icache refill request, held until if_done
//     if_addr         miss address (low index bits ignored)
//     if_rdata        refill word
//     if_rvalid       one-cycle pulse per refill word
//     if_word_idx     index of the word on if_rdata
//     if_done         one-cycle pulse with the last if_rvalid
//     dm_req          data access request, held until dm_done
//     dm_we           1 = write, 0 = read
//     dm_addr         data address
//     dm_wdata        write data
//     dm_rdata        read data, valid while dm_done is high
//     dm_done         one-cycle completion pulse
//     mem_req         memory request
//     mem_we          memory write enable
//     mem_addr        memory address
//     mem_wdata       memory write data
//     mem_rdata       memory read data, valid with mem_ack
//     mem_ack         one-cycle acknowledge; transfer on mem_req & mem_ack
//     pipe_stall      freezes all pipeline registers while a request is open
// ---------------------------------------------------------------------------
module pipe_mem_arbiter
   import pipe_mem_pkg::*;
#(
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned BLOCK_WORDS = 4
) (
   input  logic                              clk,
   input  logic                              rst_n,

   input  logic                              if_req,
   input  logic [ADDR_W-1:0]                 if_addr,
   output logic [DATA_W-1:0]                 if_rdata,
   output logic                              if_rvalid,
   output logic [idx_width(BLOCK_WORDS)-1:0] if_word_idx,
   output logic                              if_done,

   input  logic                              dm_req,
   input  logic                              dm_we,
   input  logic [ADDR_W-1:0]                 dm_addr,
   input  logic [DATA_W-1:0]                 dm_wdata,
   output logic [DATA_W-1:0]                 dm_rdata,
   output logic                              dm_done,

   output logic                              mem_req,
   output logic                              mem_we,
   output logic [ADDR_W-1:0]                 mem_addr,
   output logic [DATA_W-1:0]                 mem_wdata,
   input  logic [DATA_W-1:0]                 mem_rdata,
   input  logic                              mem_ack,

   output logic                              pipe_stall
);

   localparam int unsigned       IDX_W      = idx_width(BLOCK_WORDS);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BLOCK_WORDS - 1);

   state_t              state;
   grant_t              last_grant;
   logic [ADDR_W-1:0]   if_base;

   logic                if_valid;
   logic                dm_valid;
   logic                grant_dm;
   logic                grant_if;
   logic                xfer;
   logic                if_ack;

   logic [IDX_W-1:0]    cnt;
   logic                cnt_last;
   logic [ADDR_W-1:0]   burst_next_addr;

   // ------------------------------------------------------------------------
   // Grant logic. A requester whose done pulse is visible this cycle is still
   // holding req (it drops it this cycle), so it must not be granted again.
   // ------------------------------------------------------------------------
   assign if_valid = if_req & ~if_done;
   assign dm_valid = dm_req & ~dm_done;

   // Round-robin on contention: DM wins unless it was the last one served.
   assign grant_dm = dm_valid & (~if_valid | (last_grant == GRANT_IF));
   assign grant_if = if_valid & ~grant_dm;

   assign xfer   = mem_req & mem_ack;
   assign if_ack = (state == IF_XFER) & xfer;

   assign pipe_stall = (if_req & ~if_done) | (dm_req & ~dm_done);

   // ------------------------------------------------------------------------
   // Refill word counter and burst address adder
   // ------------------------------------------------------------------------
   refill_counter #(
      .ADDR_W      (ADDR_W),
      .BLOCK_WORDS (BLOCK_WORDS)
   ) u_refill_counter (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (state == IDLE),
      .inc       (if_ack),
      .base      (if_base),
      .cnt       (cnt),
      .last      (cnt_last),
      .next_addr (burst_next_addr)
   );

   // ------------------------------------------------------------------------
   // FSM and registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         last_grant  <= GRANT_IF;
         if_base     <= '0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         if_rdata    <= '0;
         if_rvalid   <= 1'b0;
         if_word_idx <= '0;
         if_done     <= 1'b0;
         dm_rdata    <= '0;
         dm_done     <= 1'b0;
      end else begin
         if_rvalid <= 1'b0;
         if_done   <= 1'b0;
         dm_done   <= 1'b0;

         case (state)
            IDLE: begin
               if (grant_dm) begin
                  state      <= DM_XFER;
                  last_grant <= GRANT_DM;
                  mem_req    <= 1'b1;
                  mem_we     <= dm_we;
                  mem_addr   <= dm_addr;
                  mem_wdata  <= dm_wdata;
               end else if (grant_if) begin
                  state      <= IF_XFER;
                  last_grant <= GRANT_IF;
                  if_base    <= if_addr & ALIGN_MASK;
                  mem_req    <= 1'b1;
                  mem_we     <= 1'b0;
                  mem_addr   <= if_addr & ALIGN_MASK;
               end
            end

            DM_XFER: begin
               if (xfer) begin
                  if (!mem_we) begin
                     dm_rdata <= mem_rdata;
                  end
                  dm_done <= 1'b1;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  state   <= IDLE;
               end
            end

            IF_XFER: begin
               if (if_ack) begin
                  if_rdata    <= mem_rdata;
                  if_rvalid   <= 1'b1;
                  if_word_idx <= cnt;
                  if (cnt_last) begin
                     if_done <= 1'b1;
                     mem_req <= 1'b0;
                     state   <= IDLE;
                  end else begin
                     // mem_req stays high; only the address moves on.
                     mem_addr <= burst_next_addr;
                  end
               end
            end

            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pipe_mem_arbiter
//   Directed bench for pipe_mem_arbiter. Each step queues the memory
//   transfers and requester results it expects; a memory model checks and
//   acknowledges transfers and a monitor checks the requester-side results.
// ---------------------------------------------------------------------------
module tb_pipe_mem_arbiter;

   typedef struct {
      logic [15:0] addr;
      logic        we;
      logic [15:0] wdata;
   } mem_exp_t;

   typedef struct {
      logic [15:0] data;
      logic [1:0]  idx;
      logic        done;
   } if_exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req;
   logic [15:0] if_addr;
   logic [15:0] if_rdata;
   logic        if_rvalid;
   logic [1:0]  if_word_idx;
   logic        if_done;
   logic        dm_req;
   logic        dm_we;
   logic [15:0] dm_addr;
   logic [15:0] dm_wdata;
   logic [15:0] dm_rdata;
   logic        dm_done;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = '0;
   logic        mem_ack   = 1'b0;
   logic        pipe_stall;

   mem_exp_t    exp_mem[$];
   if_exp_t     exp_if[$];
   logic [15:0] exp_dm[$];

   int unsigned passed = 0;
   int unsigned failed = 0;
   int unsigned total  = 0;

   int unsigned ack_delay   = 0;
   int unsigned wcnt        = 0;
   bit          use_fixed   = 1'b0;
   logic [15:0] fixed_rdata = '0;
   bit          stray_ack   = 1'b0;

   always #5 clk = ~clk;

   pipe_mem_arbiter #(
      .ADDR_W      (16),
      .DATA_W      (16),
      .BLOCK_WORDS (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .if_req      (if_req),
      .if_addr     (if_addr),
      .if_rdata    (if_rdata),
      .if_rvalid   (if_rvalid),
      .if_word_idx (if_word_idx),
      .if_done     (if_done),
      .dm_req      (dm_req),
      .dm_we       (dm_we),
      .dm_addr     (dm_addr),
      .dm_wdata    (dm_wdata),
      .dm_rdata    (dm_rdata),
      .dm_done     (dm_done),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ack     (mem_ack),
      .pipe_stall  (pipe_stall)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Memory model and requester-side monitor, both sampling on the falling edge.
   always @(negedge clk) begin
      mem_exp_t me;
      if_exp_t  ie;
      logic [15:0] de;

      if (if_rvalid) begin
         if (exp_if.size() == 0) begin
            check("if_rvalid_unexpected", 32'(if_rvalid), 32'(0));
         end else begin
            ie = exp_if.pop_front();
            check("if_rdata", 32'(if_rdata), 32'(ie.data));
            check("if_word_idx", 32'(if_word_idx), 32'(ie.idx));
            check("if_done", 32'(if_done), 32'(ie.done));
         end
      end else if (if_done) begin
         check("if_done_without_rvalid", 32'(if_done), 32'(0));
      end

      if (dm_done) begin
         if (exp_dm.size() == 0) begin
            check("dm_done_unexpected", 32'(dm_done), 32'(0));
         end else begin
            de = exp_dm.pop_front();
            check("dm_rdata", 32'(dm_rdata), 32'(de));
         end
      end

      mem_ack = 1'b0;
      if (stray_ack && !mem_req) begin
         mem_ack = 1'b1;
      end else if (mem_req) begin
         if (wcnt >= ack_delay) begin
            if (exp_mem.size() == 0) begin
               check("mem_req_unexpected", 32'(mem_req), 32'(0));
            end else begin
               me = exp_mem.pop_front();
               check("mem_addr", 32'(mem_addr), 32'(me.addr));
               check("mem_we", 32'(mem_we), 32'(me.we));
               if (me.we) check("mem_wdata", 32'(mem_wdata), 32'(me.wdata));
            end
            mem_ack   = 1'b1;
            mem_rdata = use_fixed ? fixed_rdata : (mem_addr ^ 16'hA5A5);
            wcnt      = 0;
         end else begin
            wcnt++;
         end
      end else begin
         wcnt = 0;
      end
   end

   task automatic push_dm(input logic [15:0] addr, input logic we,
                          input logic [15:0] wdata, input logic [15:0] rdata);
      mem_exp_t me;
      me.addr  = addr;
      me.we    = we;
      me.wdata = wdata;
      exp_mem.push_back(me);
      exp_dm.push_back(rdata);
   endtask

   task automatic push_if(input logic [15:0] base, input int unsigned words);
      mem_exp_t me;
      if_exp_t  ie;
      for (int unsigned i = 0; i < words; i++) begin
         me.addr  = base + 16'(i);
         me.we    = 1'b0;
         me.wdata = '0;
         exp_mem.push_back(me);
         ie.data = me.addr ^ 16'hA5A5;
         ie.idx  = 2'(i);
         ie.done = (i == 3);
         exp_if.push_back(ie);
      end
   endtask

   // Runs until both requesters are served and all expectations are consumed.
   // Requesters drop req in the cycle their done pulse is seen.
   task automatic run_txn(input string tag, input int unsigned budget, input int raise_dm_idx,
                          output int unsigned dm_lat, output int unsigned we_cyc);
      int unsigned cyc       = 0;
      int unsigned stall_err = 0;
      bit          busy      = 1'b1;
      dm_lat = 0;
      we_cyc = 0;
      while (busy && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (pipe_stall !== ((if_req && !if_done) || (dm_req && !dm_done))) stall_err++;
         if (mem_we) we_cyc++;
         if (dm_done && dm_lat == 0) dm_lat = cyc;
         if (raise_dm_idx >= 0 && if_rvalid && if_word_idx == 2'(raise_dm_idx)) dm_req = 1'b1;
         if (if_done) if_req = 1'b0;
         if (dm_done) dm_req = 1'b0;
         busy = if_req || dm_req || exp_if.size() != 0 || exp_dm.size() != 0 || exp_mem.size() != 0;
      end
      check({tag, "_timeout"}, 32'(busy), 32'(0));
      check({tag, "_stall"}, stall_err, 32'(0));
   endtask

   initial begin
      int unsigned lat;
      int unsigned wec;
      int unsigned cyc;

      rst_n    = 1'b0;
      if_req   = 1'b1;
      if_addr  = 16'h0502;
      dm_req   = 1'b1;
      dm_we    = 1'b0;
      dm_addr  = 16'h0300;
      dm_wdata = 16'h0000;

      // Reset with both requests pending; first contention goes to DM.
      repeat (2) @(negedge clk);
      check("rst_mem_req", 32'(mem_req), 32'(0));
      check("rst_mem_we", 32'(mem_we), 32'(0));
      check("rst_mem_addr", 32'(mem_addr), 32'(0));
      check("rst_mem_wdata", 32'(mem_wdata), 32'(0));
      check("rst_if_out", {if_rdata, 13'(0), if_rvalid, if_done, 1'b0}, 32'(0));
      check("rst_if_word_idx", 32'(if_word_idx), 32'(0));
      check("rst_dm_out", {dm_rdata, 15'(0), dm_done}, 32'(0));
      check("rst_pipe_stall", 32'(pipe_stall), 32'(1));
      push_dm(16'h0300, 1'b0, 16'h0000, 16'h0300 ^ 16'hA5A5);
      push_if(16'h0500, 4);
      rst_n = 1'b1;
      @(negedge clk);
      check("first_grant_mem_req", 32'(mem_req), 32'(1));
      check("first_grant_mem_addr", 32'(mem_addr), 32'(16'h0300));
      run_txn("contend_dm_first", 60, -1, lat, wec);
      repeat (2) @(negedge clk);

      // DM read with three wait cycles.
      ack_delay   = 3;
      use_fixed   = 1'b1;
      fixed_rdata = 16'hBEEF;
      dm_we   = 1'b0;
      dm_addr = 16'h0040;
      push_dm(16'h0040, 1'b0, 16'h0000, 16'hBEEF);
      dm_req = 1'b1;
      run_txn("dm_read", 40, -1, lat, wec);
      check("dm_read_latency", lat, 32'(5));
      use_fixed = 1'b0;
      ack_delay = 0;
      repeat (2) @(negedge clk);

      // DM write with immediate ack; dm_rdata keeps the last read value.
      dm_we    = 1'b1;
      dm_addr  = 16'h0010;
      dm_wdata = 16'h1234;
      push_dm(16'h0010, 1'b1, 16'h1234, 16'hBEEF);
      dm_req = 1'b1;
      run_txn("dm_write", 40, -1, lat, wec);
      check("dm_write_latency", lat, 32'(2));
      check("dm_write_we_cycles", wec, 32'(1));
      repeat (2) @(negedge clk);

      // Contention after a DM grant: IF is served first.
      if_addr  = 16'h0806;
      dm_we    = 1'b1;
      dm_addr  = 16'h0022;
      dm_wdata = 16'h5A5A;
      push_if(16'h0804, 4);
      push_dm(16'h0022, 1'b1, 16'h5A5A, 16'hBEEF);
      if_req = 1'b1;
      dm_req = 1'b1;
      run_txn("contend_if_first", 60, -1, lat, wec);
      repeat (2) @(negedge clk);

      // Refill whose block sits at the top of the address space.
      if_addr = 16'hFFFE;
      push_if(16'hFFFC, 4);
      if_req = 1'b1;
      run_txn("if_wrap", 40, -1, lat, wec);
      repeat (2) @(negedge clk);

      // DM request arriving mid-burst waits for if_done.
      ack_delay = 1;
      if_addr   = 16'h1000;
      dm_we     = 1'b0;
      dm_addr   = 16'h2000;
      push_if(16'h1000, 4);
      push_dm(16'h2000, 1'b0, 16'h0000, 16'h2000 ^ 16'hA5A5);
      if_req = 1'b1;
      run_txn("dm_mid_burst", 80, 0, lat, wec);
      ack_delay = 0;
      repeat (2) @(negedge clk);

      // Acknowledge with no request outstanding is ignored.
      stray_ack = 1'b1;
      repeat (2) @(negedge clk);
      stray_ack = 1'b0;
      repeat (2) @(negedge clk);
      check("stray_ack_mem_req", 32'(mem_req), 32'(0));
      check("stray_ack_outputs", {29'(0), if_rvalid, if_done, dm_done}, 32'(0));

      // Reset after word 1 abandons the burst; a new request starts at word 0.
      ack_delay = 2;
      if_addr   = 16'h0340;
      push_if(16'h0340, 2);
      if_req = 1'b1;
      cyc = 0;
      while (!(if_rvalid && if_word_idx == 2'd1) && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
      check("rst_mid_wait_timeout", 32'(if_rvalid && if_word_idx == 2'd1), 32'(1));
      rst_n  = 1'b0;
      if_req = 1'b0;
      @(negedge clk);
      check("rst_mid_mem_req", 32'(mem_req), 32'(0));
      check("rst_mid_if_done", 32'(if_done), 32'(0));
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_mid_idle_mem_req", 32'(mem_req), 32'(0));
      ack_delay = 0;
      if_addr   = 16'h0120;
      push_if(16'h0120, 4);
      if_req = 1'b1;
      run_txn("refill_restart", 40, -1, lat, wec);

      check("left_exp_mem", 32'(exp_mem.size()), 32'(0));
      check("left_exp_if", 32'(exp_if.size()), 32'(0));
      check("left_exp_dm", 32'(exp_dm.size()), 32'(0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
